// File: rtl/alu_op_arbiter.sv
// Two-requester sequencer for the shared gate-level ALU: grant, hold inputs for SETTLE_CYCLES, capture, ack.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins) instead of round-robin.
module alu_op_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic [2:0] op0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic       c0,
  output logic       ack0,
  input  logic       req1,
  input  logic [2:0] op1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic       c1,
  output logic       ack1,
  output logic [3:0] result,
  output logic       carry,
  output logic [2:0] alu_mode,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_c,
  input  logic [3:0] alu_regout,
  input  logic       alu_carryout,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       grant, capture, winner;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign winner = ~req0;
`else
  logic last_grant;

  // Contention goes to whoever was not served last; a lone request always wins.
  assign winner = (req0 && req1) ? ~last_grant : req1;

  always_ff @(posedge clock) begin
    if (reset)      last_grant <= 1'b1;
    else if (grant) last_grant <= winner;
  end
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    grant      = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant      = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      result   <= '0;
      carry    <= 1'b0;
      alu_mode <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_c    <= 1'b0;
      grant_id <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (grant) begin
        grant_id <= winner;
        alu_mode <= winner ? op1 : op0;
        alu_a    <= winner ? a1  : a0;
        alu_b    <= winner ? b1  : b0;
        alu_c    <= winner ? c1  : c0;
      end
      if (capture) begin
        result <= alu_regout;
        carry  <= alu_carryout;
      end
    end
  end

  assign busy = (state != IDLE);
  assign ack0 = (state == DONE) && !grant_id;
  assign ack1 = (state == DONE) &&  grant_id;

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Directed self-checking bench for alu_op_arbiter with a behavioural stand-in for the gate-level ALU.
module tb_alu_op_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0, c0, req1, c1;
  logic [2:0] op0, op1;
  logic [3:0] a0, b0, a1, b1;
  logic       ack0, ack1, carry, alu_c, alu_carryout, busy, grant_id;
  logic [3:0] result, alu_a, alu_b, alu_regout;
  logic [2:0] alu_mode;
  logic [4:0] sum;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  alu_op_arbiter #(.SETTLE_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .c0(c0), .ack0(ack0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .c1(c1), .ack1(ack1),
    .result(result), .carry(carry),
    .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_regout(alu_regout), .alu_carryout(alu_carryout),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  // Stand-in ALU: 000 A, 001 A+B+C, 010 AND, 011 OR, 100 XOR, 101 A+~B+C, 110 ~A, 111 B
  always_comb begin
    sum = '0;
    case (alu_mode)
      3'b000:  sum = {1'b0, alu_a};
      3'b001:  sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_c};
      3'b010:  sum = {1'b0, alu_a & alu_b};
      3'b011:  sum = {1'b0, alu_a | alu_b};
      3'b100:  sum = {1'b0, alu_a ^ alu_b};
      3'b101:  sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, alu_c};
      3'b110:  sum = {1'b0, ~alu_a};
      default: sum = {1'b0, alu_b};
    endcase
    alu_regout   = sum[3:0];
    alu_carryout = sum[4];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts falling edges until an ack appears (bounded), then checks latency and which ack.
  task automatic wait_ack(input string tag, input logic exp_id, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(ack0 || ack1) && n < 20);
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_acks"}, {ack0, ack1}, exp_id ? 2'b01 : 2'b10);
    chk({tag, "_gid"}, grant_id, exp_id);
  endtask

  initial begin
    logic seen;
    logic exp_id;
    reset = 1'b1;
    req0 = 0; op0 = '0; a0 = '0; b0 = '0; c0 = 0;
    req1 = 0; op1 = '0; a1 = '0; b1 = '0; c1 = 0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_acks", {ack0, ack1}, 0);
    chk("rst_res", {carry, result}, 0);
    chk("rst_alu", {alu_mode, alu_a, alu_b, alu_c}, 0);
    chk("rst_gid", grant_id, 0);

    // Single op from requester 0: 0111 + 0001 + 0
    req0 = 1; op0 = 3'b001; a0 = 4'b0111; b0 = 4'b0001; c0 = 0;
    @(negedge clock);
    chk("op1_busy", busy, 1);
    chk("op1_alu", {alu_mode, alu_a, alu_b, alu_c}, {3'b001, 4'b0111, 4'b0001, 1'b0});
    wait_ack("op1", 0, 4);
    chk("op1_res", {carry, result}, 5'b0_1000);
    req0 = 0;
    @(negedge clock);
    chk("op1_pulse", {ack0, ack1}, 0);
    @(negedge clock);
    chk("op1_idle", busy, 0);

    // Carry out from requester 1: 1111 + 0001 + 1
    req1 = 1; op1 = 3'b001; a1 = 4'b1111; b1 = 4'b0001; c1 = 1;
    wait_ack("op2", 1, 5);
    chk("op2_res", {carry, result}, 5'b1_0001);
    req1 = 0;
    @(negedge clock);
    @(negedge clock);

    // Contention after reset
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    req0 = 1; op0 = 3'b010; a0 = 4'b1100; b0 = 4'b1010; c0 = 0;
    req1 = 1; op1 = 3'b011; a1 = 4'b0011; b1 = 4'b0100; c1 = 0;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = (i % 2 == 1);
`endif
      wait_ack($sformatf("cont%0d", i), exp_id, (i == 0) ? 5 : 6);
      chk($sformatf("cont%0d_res", i), result, exp_id ? 4'b0111 : 4'b1000);
    end
    req0 = 0;
    wait_ack("cont_tail", 1, 6);
    chk("cont_tail_res", result, 4'b0111);
    req1 = 0;
    @(negedge clock);
    @(negedge clock);

    // Reset sampled at grant edge + 2 discards the op
    req0 = 1; op0 = 3'b001; a0 = 4'b0011; b0 = 4'b0011; c0 = 0;
    @(negedge clock);
    chk("mid_busy", busy, 1);
    @(negedge clock);
    reset = 1'b1; req0 = 0;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_busy0", busy, 0);
    chk("mid_res", {carry, result}, 0);
    chk("mid_alu", {alu_mode, alu_a, alu_b, alu_c}, 0);
    chk("mid_gid", grant_id, 0);
    seen = 0;
    repeat (8) begin
      @(negedge clock);
      seen = seen | ack0 | ack1 | busy;
    end
    chk("mid_quiet", seen, 0);
    req0 = 1; op0 = 3'b010; a0 = 4'b1100; b0 = 4'b1010; c0 = 0;
    wait_ack("post_rst", 0, 5);
    chk("post_rst_res", result, 4'b1000);
    req0 = 0;
    @(negedge clock);
    @(negedge clock);

    // Operand change after the grant edge is ignored
    req0 = 1; op0 = 3'b100; a0 = 4'b0101; b0 = 4'b0011; c0 = 0;
    @(negedge clock);
    a0 = 4'b1111;
    @(negedge clock);
    chk("late_alu_a", alu_a, 4'b0101);
    wait_ack("late", 0, 3);
    chk("late_res", {carry, result}, 5'b0_0110);
    req0 = 0;
    @(negedge clock);
    @(negedge clock);

    // Requester 1 drops req mid-op; op still completes
    req1 = 1; op1 = 3'b110; a1 = 4'b0101; b1 = 4'b0000; c1 = 0;
    @(negedge clock);
    req1 = 0;
    wait_ack("drop", 1, 4);
    chk("drop_res", {carry, result}, 5'b0_1010);
    repeat (4) @(negedge clock);
    chk("hold_alu", {alu_mode, alu_a}, {3'b110, 4'b0101});
    chk("hold_idle", {busy, ack0, ack1}, 0);
    chk("hold_res", result, 4'b1010);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
